// File: rtl/branch_pkg.sv
// Shared types and widths for the branch controller.
package branch_pkg;

  localparam int unsigned BrOpW     = 3;
  localparam int unsigned FlushCntW = 2;

  // Decoded branch operation; encodings 6 and 7 behave as NOP.
  typedef enum logic [BrOpW-1:0] {
    BrNop  = 3'd0,
    BrBrc  = 3'd1,
    BrBra  = 3'd2,
    BrJmp  = 3'd3,
    BrCall = 3'd4,
    BrRet  = 3'd5
  } br_op_t;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StSquash = 1'b1
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack. Push into a full stack and pop from an empty
// stack are ignored; the caller is responsible for flagging the error.
module ret_stack #(
  parameter int unsigned D        = 12,
  parameter int unsigned RS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW  = $clog2(RS_DEPTH);
  localparam int unsigned SpW = AW + 1;

  logic [SpW-1:0] sp_q, sp_d;
  logic [SpW-1:0] sp_m1;
  logic [D-1:0]   mem_q [RS_DEPTH];
  logic [D-1:0]   mem_d [RS_DEPTH];

  assign full  = (sp_q == SpW'(RS_DEPTH));
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - SpW'(1);
  // Index wraps when empty; the value is never used in that case.
  assign top   = mem_q[sp_m1[AW-1:0]];

  // Next-state: push has priority; blocked operations leave the stack untouched.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[sp_q[AW-1:0]] = push_data;
      sp_d                = sp_q + SpW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_m1;
    end
  end

  // Stack pointer and storage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: turns decoded branch ops into PC control, holding the
// condition flag, jump-target LUT, return stack and post-branch squash FSM.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned D         = 12,
  parameter int unsigned LUT_AW    = 4,
  parameter int unsigned RS_DEPTH  = 4,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [D-1:0]      prog_ctr,
  input  logic [BrOpW-1:0]  br_op,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              flag_we,
  input  logic              flag_in,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [D-1:0]      lut_wdata,
  output logic              branch,
  output logic              jump_flag,
  output logic              absjump_en,
  output logic [D-1:0]      target,
  output logic              squash,
  output logic              rs_err
);

  localparam int unsigned LutN = 2 ** LUT_AW;

  state_t               state_q, state_d;
  logic [FlushCntW-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;
  logic                 rs_err_q, rs_err_d;
  logic [D-1:0]         lut_q [LutN];
  logic [D-1:0]         lut_d [LutN];

  logic         rs_push, rs_pop, rs_full, rs_empty, err_set;
  logic [D-1:0] rs_top, lut_rd;

  assign lut_rd = lut_q[lut_idx];
  assign squash = (state_q == StSquash);
  assign rs_err = rs_err_q;

  ret_stack #(
    .D        (D),
    .RS_DEPTH (RS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (prog_ctr + D'(1)),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  // Output decode; ops only act while running, squash ignores them entirely.
  always_comb begin
    branch     = 1'b0;
    jump_flag  = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
    err_set    = 1'b0;
    if (state_q == StRun) begin
      case (br_op)
        BrBrc: begin
          branch    = 1'b1;
          jump_flag = flag_q;
          target    = lut_rd;
        end
        BrBra: begin
          branch     = 1'b1;
          jump_flag  = flag_q;
          absjump_en = 1'b1;
          target     = lut_rd;
        end
        BrJmp: begin
          branch     = 1'b1;
          jump_flag  = 1'b1;
          absjump_en = 1'b1;
          target     = lut_rd;
        end
        BrCall: begin
          // The jump still happens when the stack is full; only the push is lost.
          branch     = 1'b1;
          jump_flag  = 1'b1;
          absjump_en = 1'b1;
          target     = lut_rd;
          rs_push    = !rs_full;
          err_set    = rs_full;
        end
        BrRet: begin
          if (rs_empty) begin
            err_set = 1'b1;
          end else begin
            branch     = 1'b1;
            jump_flag  = 1'b1;
            absjump_en = 1'b1;
            target     = rs_top;
            rs_pop     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Squash FSM with down-counter, plus flag, LUT and sticky error next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flag_d   = flag_we ? flag_in : flag_q;
    rs_err_d = rs_err_q | err_set;
    lut_d    = lut_q;
    if (lut_we) lut_d[lut_waddr] = lut_wdata;
    case (state_q)
      StRun: begin
        if (branch && jump_flag) begin
          state_d = StSquash;
          cnt_d   = FlushCntW'(FLUSH_CYC - 1);
        end
      end
      StSquash: begin
        if (cnt_q == '0) state_d = StRun;
        else             cnt_d   = cnt_q - FlushCntW'(1);
      end
      default: state_d = StRun;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      rs_err_q <= 1'b0;
      for (int i = 0; i < LutN; i++) lut_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      rs_err_q <= rs_err_d;
      lut_q    <= lut_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl: one FLUSH_CYC=1 instance and one
// FLUSH_CYC=3 instance sharing stimulus.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  logic [2:0]  br_op;
  logic [3:0]  lut_idx;
  logic        flag_we, flag_in, lut_we;
  logic [3:0]  lut_waddr;
  logic [11:0] lut_wdata;

  logic        branch, jump_flag, absjump_en, squash, rs_err;
  logic [11:0] target;
  logic        branch3, jump_flag3, absjump_en3, squash3, rs_err3;
  logic [11:0] target3;

  // {branch, jump_flag, absjump_en, squash, target}
  logic [15:0] obs, obs3;
  assign obs  = {branch, jump_flag, absjump_en, squash, target};
  assign obs3 = {branch3, jump_flag3, absjump_en3, squash3, target3};

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] NOP = 3'd0, BRC = 3'd1, BRA = 3'd2, JMP = 3'd3, CALL = 3'd4,
                         RET = 3'd5;

  always #5 clk = ~clk;

  branch_ctrl #(.D(12), .LUT_AW(4), .RS_DEPTH(4), .FLUSH_CYC(1)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .br_op(br_op), .lut_idx(lut_idx),
    .flag_we(flag_we), .flag_in(flag_in), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .branch(branch), .jump_flag(jump_flag), .absjump_en(absjump_en),
    .target(target), .squash(squash), .rs_err(rs_err)
  );

  branch_ctrl #(.D(12), .LUT_AW(4), .RS_DEPTH(4), .FLUSH_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .br_op(br_op), .lut_idx(lut_idx),
    .flag_we(flag_we), .flag_in(flag_in), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .branch(branch3), .jump_flag(jump_flag3),
    .absjump_en(absjump_en3), .target(target3), .squash(squash3), .rs_err(rs_err3)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] idx);
    br_op   = op;
    lut_idx = idx;
    #1;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [11:0] d);
    br_op     = NOP;
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = d;
    cyc();
    lut_we    = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; prog_ctr = '0; br_op = NOP; lut_idx = '0;
    flag_we = 0; flag_in = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    cyc();
    n_checks++;
    if (obs !== 16'h0 || rs_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b want 0000/0", obs, rs_err);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 4'd0);
      n_checks++;
      if (obs !== 16'h0 || rs_err !== 1'b0 || obs3 !== 16'h0) begin
        n_fail++; $display("FAIL nop_idle%0d: got %h/%b want 0000/0", i, obs, rs_err);
      end
      cyc();
    end
  endtask

  task automatic test_flag_brc();
    lut_write(4'd2, 12'd5);
    // Flag written in the same cycle as BRC: old flag (0) is used.
    flag_we = 1; flag_in = 1;
    drive(BRC, 4'd2);
    n_checks++;
    if (obs !== {4'b1000, 12'd5}) begin
      n_fail++; $display("FAIL brc_same_cycle_flag: got %h want %h", obs, {4'b1000, 12'd5});
    end
    cyc();
    flag_we = 0;
    drive(NOP, 4'd0);
    n_checks++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL brc_not_taken_no_squash: got %h want 0000", obs);
    end
    flag_we = 1; flag_in = 0;
    cyc();
    // Cycle n: load flag=1.
    flag_in = 1;
    drive(NOP, 4'd0);
    cyc();
    // Cycle n+1: taken relative branch.
    flag_we = 0;
    drive(BRC, 4'd2);
    n_checks++;
    if (obs !== {4'b1100, 12'd5}) begin
      n_fail++; $display("FAIL brc_taken: got %h want %h", obs, {4'b1100, 12'd5});
    end
    cyc();
    drive(NOP, 4'd0);
    n_checks++;
    if (obs !== {4'b0001, 12'd0}) begin
      n_fail++; $display("FAIL brc_squash_n2: got %h want 1000", obs);
    end
    cyc();
    n_checks++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL brc_squash_n3: got %h want 0000", obs);
    end
  endtask

  task automatic test_rel_wrap();
    lut_write(4'd3, 12'hFFF);
    prog_ctr = 12'h010;
    drive(BRC, 4'd3);
    n_checks++;
    if (obs !== {4'b1100, 12'hFFF}) begin
      n_fail++; $display("FAIL brc_neg_offset: got %h want %h", obs, {4'b1100, 12'hFFF});
    end
    cyc();
    drive(NOP, 4'd0);
    cyc();
    // Write and read LUT[3] in the same cycle: old entry seen.
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 12'h123;
    drive(BRA, 4'd3);
    n_checks++;
    if (obs !== {4'b1110, 12'hFFF}) begin
      n_fail++; $display("FAIL lut_same_cycle_old: got %h want %h", obs, {4'b1110, 12'hFFF});
    end
    cyc();
    lut_we = 0;
    drive(NOP, 4'd0);
    cyc();
    drive(BRA, 4'd3);
    n_checks++;
    if (obs !== {4'b1110, 12'h123}) begin
      n_fail++; $display("FAIL lut_new_value: got %h want %h", obs, {4'b1110, 12'h123});
    end
    cyc();
    drive(NOP, 4'd0);
    cyc();
  endtask

  task automatic test_call_ret();
    lut_write(4'd1, 12'h100);
    prog_ctr = 12'h020;
    drive(CALL, 4'd1);
    n_checks++;
    if (obs !== {4'b1110, 12'h100}) begin
      n_fail++; $display("FAIL call_outputs: got %h want %h", obs, {4'b1110, 12'h100});
    end
    cyc();
    prog_ctr = 12'h100;
    drive(NOP, 4'd0);
    n_checks++;
    if (obs !== {4'b0001, 12'h0}) begin
      n_fail++; $display("FAIL call_squash: got %h want 1000", obs);
    end
    cyc();
    drive(RET, 4'd0);
    n_checks++;
    if (obs !== {4'b1110, 12'h021} || rs_err !== 1'b0) begin
      n_fail++; $display("FAIL ret_target: got %h/%b want %h/0", obs, rs_err, {4'b1110, 12'h021});
    end
    cyc();
    drive(NOP, 4'd0);
    cyc();
    drive(RET, 4'd0);
    n_checks++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL ret_empty_no_branch: got %h want 0000", obs);
    end
    cyc();
    drive(NOP, 4'd0);
    n_checks++;
    if (obs !== 16'h0 || rs_err !== 1'b1) begin
      n_fail++; $display("FAIL ret_empty_err: got %h/%b want 0000/1", obs, rs_err);
    end
    cyc(); cyc();
    n_checks++;
    if (rs_err !== 1'b1) begin
      n_fail++; $display("FAIL rs_err_sticky: got %b want 1", rs_err);
    end
  endtask

  task automatic test_stack_overflow();
    pulse_reset();
    n_checks++;
    if (rs_err !== 1'b0) begin
      n_fail++; $display("FAIL rs_err_reset: got %b want 0", rs_err);
    end
    cyc();
    lut_write(4'd1, 12'h100);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        n_checks++;
        if (rs_err !== 1'b0) begin
          n_fail++; $display("FAIL rs_err_before_full: got %b want 0", rs_err);
        end
      end
      prog_ctr = 12'h030 + 12'(16 * i);
      drive(CALL, 4'd1);
      n_checks++;
      if (obs !== {4'b1110, 12'h100}) begin
        n_fail++; $display("FAIL call%0d_outputs: got %h want %h", i, obs, {4'b1110, 12'h100});
      end
      cyc();
      drive(NOP, 4'd0);
      cyc();
    end
    n_checks++;
    if (rs_err !== 1'b1) begin
      n_fail++; $display("FAIL overflow_err: got %b want 1", rs_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(RET, 4'd0);
      n_checks++;
      if (obs !== {4'b1110, 12'h061 - 12'(16 * i)}) begin
        n_fail++; $display("FAIL ret%0d_lifo: got %h want %h", i, obs,
                           {4'b1110, 12'h061 - 12'(16 * i)});
      end
      cyc();
      drive(NOP, 4'd0);
      cyc();
    end
    drive(RET, 4'd0);
    n_checks++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL ret_after_drain: got %h want 0000", obs);
    end
    cyc();
  endtask

  task automatic test_squash_len();
    pulse_reset();
    cyc();
    lut_write(4'd4, 12'h2AB);
    drive(JMP, 4'd4);
    n_checks++;
    if (obs3 !== {4'b1110, 12'h2AB}) begin
      n_fail++; $display("FAIL jmp_outputs: got %h want %h", obs3, {4'b1110, 12'h2AB});
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      // JMP held on the op bus throughout squash must be ignored.
      drive(JMP, 4'd4);
      n_checks++;
      if (obs3 !== {4'b0001, 12'h0}) begin
        n_fail++; $display("FAIL squash3_cycle%0d: got %h want 1000", i + 1, obs3);
      end
      cyc();
    end
    drive(NOP, 4'd0);
    n_checks++;
    if (obs3 !== 16'h0) begin
      n_fail++; $display("FAIL squash3_end: got %h want 0000", obs3);
    end
    // Reset during the second squash cycle.
    drive(JMP, 4'd4);
    cyc();
    drive(NOP, 4'd0);
    cyc();
    n_checks++;
    if (squash3 !== 1'b1) begin
      n_fail++; $display("FAIL squash3_before_reset: got %b want 1", squash3);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs3 !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_squash: got %h want 0000", obs3);
    end
    reset = 1'b0;
    cyc();
    lut_write(4'd4, 12'h2AB);
    drive(JMP, 4'd4);
    n_checks++;
    if (obs3 !== {4'b1110, 12'h2AB}) begin
      n_fail++; $display("FAIL run_after_reset: got %h want %h", obs3, {4'b1110, 12'h2AB});
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_flag_brc();
    test_rel_wrap();
    test_call_ret();
    test_stack_overflow();
    test_squash_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
